// File: rtl/proc_traffic_gen_pkg.sv
// Shared types for the processor traffic generator: LSU op encoding, data type,
// generator FSM states and the store-data pattern.
package proc_traffic_gen_pkg;

  localparam int MEM_IDS    = 8;
  localparam int DATA_WIDTH = 64;

  typedef logic [DATA_WIDTH-1:0] data_t;

  typedef enum logic {
    LSU_LOAD  = 1'b0,
    LSU_STORE = 1'b1
  } lsu_op_e;

  typedef enum logic [2:0] {
    IDLE,
    STORE,
    LOAD,
    DRAIN,
    DONE
  } tg_state_e;

  function automatic data_t pattern(input logic [31:0] i, input logic [31:0] seed);
    return data_t'(seed ^ i);
  endfunction

endpackage

// File: rtl/proc_traffic_gen_id_pool.sv
// Load-tag pool: busy bitmap with lowest-free priority encoder.
// A tag freed in a cycle only becomes visible as free after the clock edge.
module proc_traffic_gen_id_pool #(
  parameter int MEM_IDS = 8,
  localparam int IDW = (MEM_IDS > 1) ? $clog2(MEM_IDS) : 1
) (
  input  logic               clk_sys,
  input  logic               rst_b,
  input  logic               en,
  input  logic               clear,
  input  logic               alloc,
  input  logic [IDW-1:0]     alloc_id,
  input  logic               free,
  input  logic [IDW-1:0]     free_id,
  output logic [MEM_IDS-1:0] busy,
  output logic [IDW-1:0]     lowest_free,
  output logic               any_free,
  output logic               all_free
);

  logic [MEM_IDS-1:0] alloc_mask;
  logic [MEM_IDS-1:0] free_mask;

  assign alloc_mask = MEM_IDS'(alloc) << alloc_id;
  assign free_mask  = MEM_IDS'(free) << free_id;
  assign any_free   = ~&busy;
  assign all_free   = ~|busy;

  always_comb begin
    lowest_free = '0;
    for (int k = MEM_IDS - 1; k >= 0; k--) begin
      if (!busy[k]) lowest_free = IDW'(k);
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!rst_b) begin
      busy <= '0;
    end else if (en) begin
      if (clear) busy <= '0;
      else       busy <= (busy & ~free_mask) | alloc_mask;
    end
  end

endmodule

// File: rtl/proc_traffic_gen.sv
// Self-checking memory-traffic generator: NUM_OPS stores then NUM_OPS tagged loads,
// responses checked against the stored pattern. Optional watchdog: PROC_TRAFFIC_GEN_TIMEOUT_EN.
//   state | meaning
//   IDLE  | waiting for start_in
//   STORE | presenting store op_cnt
//   LOAD  | presenting load op_cnt when a tag is free
//   DRAIN | all loads issued, waiting for outstanding tags
//   DONE  | run complete, done_out high until restart
module proc_traffic_gen #(
  parameter int MEM_IDS = 8,
  parameter int NUM_OPS = 16,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter logic [ADDR_WIDTH-1:0] ADDR_BASE = 'h1000,
  parameter int unsigned ADDR_STRIDE = 8,
  parameter logic [31:0] PATTERN_SEED = 32'hA5A5_0000,
  parameter int TIMEOUT_CYC = 256,
  localparam int IDW = (MEM_IDS > 1) ? $clog2(MEM_IDS) : 1
) (
  input  logic                           clk_in,
  input  logic                           rst_N_in,
  input  logic                           cs_N_in,
  input  logic                           start_in,
  input  logic                           lsu_ready_in,
  output logic                           valid_out,
  output proc_traffic_gen_pkg::lsu_op_e  lsu_op_out,
  output logic [IDW-1:0]                 mem_id_out,
  output logic [ADDR_WIDTH-1:0]          addr_out,
  output logic [DATA_WIDTH-1:0]          data_out,
  input  logic                           load_valid_in,
  input  logic [IDW-1:0]                 load_id_in,
  input  logic [DATA_WIDTH-1:0]          load_data_in,
  output logic                           done_out,
  output logic [15:0]                    err_count_out,
  output logic [15:0]                    spurious_count_out
`ifdef PROC_TRAFFIC_GEN_TIMEOUT_EN
  ,
  output logic                           timeout_out
`endif
);
  import proc_traffic_gen_pkg::*;

  localparam int OPW = $clog2(NUM_OPS + 1);
  localparam logic [OPW-1:0] LAST_OP = OPW'(NUM_OPS - 1);

  tg_state_e             state, state_nxt;
  logic [OPW-1:0]        op_cnt;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [OPW-1:0]        tag_op [MEM_IDS];
  logic [15:0]           err_cnt, spur_cnt;
  logic                  req_held;
  logic [IDW-1:0]        held_id;

  logic                  valid_c;
  lsu_op_e               op_c;
  logic [IDW-1:0]        id_c;
  logic [ADDR_WIDTH-1:0] addr_c;
  logic [DATA_WIDTH-1:0] data_c;

  logic [MEM_IDS-1:0]    busy;
  logic [IDW-1:0]        lowest_free;
  logic                  any_free, all_free;
  logic                  en, hs, load_hs, rsp, rsp_busy, rsp_bad, start_ok, to_fire;

  function automatic logic [DATA_WIDTH-1:0] pat(input logic [OPW-1:0] i);
    return DATA_WIDTH'(pattern(32'(i), PATTERN_SEED));
  endfunction

  assign en       = !cs_N_in;
  assign hs       = en && valid_c && lsu_ready_in;
  assign load_hs  = hs && (state == LOAD);
  assign rsp      = en && load_valid_in && (state != IDLE);
  assign rsp_busy = rsp && busy[load_id_in];
  assign rsp_bad  = rsp_busy && (load_data_in != pat(tag_op[load_id_in]));
  assign start_ok = en && start_in && ((state == IDLE) || (state == DONE));

  always_comb begin
    state_nxt = state;
    valid_c   = 1'b0;
    op_c      = LSU_LOAD;
    id_c      = '0;
    addr_c    = '0;
    data_c    = '0;
    case (state)
      IDLE:  if (start_in) state_nxt = STORE;
      STORE: begin
        valid_c = 1'b1;
        op_c    = LSU_STORE;
        addr_c  = cur_addr;
        data_c  = pat(op_cnt);
        if (lsu_ready_in && op_cnt == LAST_OP) state_nxt = LOAD;
      end
      LOAD: begin
        // a presented load keeps its tag even if a lower one frees meanwhile
        valid_c = req_held || any_free;
        id_c    = req_held ? held_id : lowest_free;
        addr_c  = cur_addr;
        if (valid_c && lsu_ready_in && op_cnt == LAST_OP) state_nxt = DRAIN;
      end
      DRAIN: if (all_free) state_nxt = DONE;
      DONE:  if (start_in) state_nxt = STORE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_N_in) begin
      state    <= IDLE;
      op_cnt   <= '0;
      cur_addr <= ADDR_BASE;
      err_cnt  <= '0;
      spur_cnt <= '0;
      req_held <= 1'b0;
      held_id  <= '0;
    end else if (en) begin
      state    <= to_fire ? DONE : state_nxt;
      req_held <= !to_fire && (state == LOAD) && valid_c && !lsu_ready_in;
      held_id  <= id_c;
      if (start_ok) begin
        op_cnt   <= '0;
        cur_addr <= ADDR_BASE;
        err_cnt  <= '0;
        spur_cnt <= '0;
      end else begin
        if (hs) begin
          op_cnt   <= (op_cnt == LAST_OP) ? '0 : op_cnt + 1'b1;
          cur_addr <= (state == STORE && op_cnt == LAST_OP) ? ADDR_BASE
                                                            : cur_addr + ADDR_WIDTH'(ADDR_STRIDE);
        end
        if (rsp_bad && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
        if (rsp && !rsp_busy && spur_cnt != 16'hFFFF) spur_cnt <= spur_cnt + 16'd1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (en && load_hs) tag_op[id_c] <= op_cnt;
  end

  proc_traffic_gen_id_pool #(.MEM_IDS(MEM_IDS)) u_id_pool (
    .clk_sys     (clk_in),
    .rst_b       (rst_N_in),
    .en          (en),
    .clear       (to_fire),
    .alloc       (load_hs),
    .alloc_id    (id_c),
    .free        (rsp_busy),
    .free_id     (load_id_in),
    .busy        (busy),
    .lowest_free (lowest_free),
    .any_free    (any_free),
    .all_free    (all_free)
  );

`ifdef PROC_TRAFFIC_GEN_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT_CYC + 1);
  logic [WDW-1:0] wd_cnt;
  logic           to_q;

  assign to_fire = en && !hs && !rsp && !all_free && (wd_cnt == WDW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk_in) begin
    if (!rst_N_in) begin
      wd_cnt <= '0;
      to_q   <= 1'b0;
    end else if (en) begin
      if (start_ok)     to_q <= 1'b0;
      else if (to_fire) to_q <= 1'b1;
      if (hs || rsp || all_free || to_fire) wd_cnt <= '0;
      else                                  wd_cnt <= wd_cnt + 1'b1;
    end
  end

  assign timeout_out = cs_N_in ? 1'bz : to_q;
`else
  assign to_fire = 1'b0;
`endif

  assign valid_out          = cs_N_in ? 1'bz : valid_c;
  assign lsu_op_out         = cs_N_in ? lsu_op_e'(1'bz) : op_c;
  assign mem_id_out         = cs_N_in ? 'z : id_c;
  assign addr_out           = cs_N_in ? 'z : addr_c;
  assign data_out           = cs_N_in ? 'z : data_c;
  assign done_out           = cs_N_in ? 1'bz : (state == DONE);
  assign err_count_out      = cs_N_in ? 'z : err_cnt;
  assign spurious_count_out = cs_N_in ? 'z : spur_cnt;

endmodule

// File: tb/tb_proc_traffic_gen.sv
// Scoreboard bench for proc_traffic_gen: expected requests are queued at start,
// popped on each handshake; a tag-pool model drives the load responder.
module tb_proc_traffic_gen;
  import proc_traffic_gen_pkg::*;

  logic        clk_in = 1'b0;
  logic        rst_N_in, cs_N_in, start_in, lsu_ready_in, load_valid_in;
  logic [2:0]  load_id_in;
  logic [63:0] load_data_in;
  logic        valid_out;
  lsu_op_e     lsu_op_out;
  logic [2:0]  mem_id_out;
  logic [31:0] addr_out;
  logic [63:0] data_out;
  logic        done_out;
  logic [15:0] err_count_out, spurious_count_out;
`ifdef PROC_TRAFFIC_GEN_TIMEOUT_EN
  logic        timeout_out;
`endif

  always #5 clk_in = ~clk_in;

  proc_traffic_gen #(.TIMEOUT_CYC(20)) dut (
    .clk_in             (clk_in),
    .rst_N_in           (rst_N_in),
    .cs_N_in            (cs_N_in),
    .start_in           (start_in),
    .lsu_ready_in       (lsu_ready_in),
    .valid_out          (valid_out),
    .lsu_op_out         (lsu_op_out),
    .mem_id_out         (mem_id_out),
    .addr_out           (addr_out),
    .data_out           (data_out),
    .load_valid_in      (load_valid_in),
    .load_id_in         (load_id_in),
    .load_data_in       (load_data_in),
    .done_out           (done_out),
    .err_count_out      (err_count_out),
    .spurious_count_out (spurious_count_out)
`ifdef PROC_TRAFFIC_GEN_TIMEOUT_EN
    ,
    .timeout_out        (timeout_out)
`endif
  );

  typedef struct {bit is_store; logic [31:0] addr; logic [63:0] data;} req_t;
  typedef struct {int id; logic [63:0] data; int due;} rsp_t;

  req_t exp_q[$];
  rsp_t rsp_q[$];
  logic [7:0] mdl_busy;
  int mdl_tag[8];
  int n_chk = 0, n_err = 0;
  int exp_err, exp_spur, n_st, n_ld, cyc, last_act, reuse_cyc, held_exp_id, corrupt_id;
  bit mdl_active, hold_all, hold_test, rand_ready, drop_last, cur_exp_held;
  bit reuse_armed, reuse_seen, stall_seen;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] pat(input int i);
    return {32'h0, 32'hA5A5_0000 ^ 32'(i)};
  endfunction

  function automatic int lowest(input logic [7:0] b);
    for (int k = 0; k < 8; k++) if (!b[k]) return k;
    return 0;
  endfunction

  task automatic sample_and_model();
    logic [7:0] pre;
    req_t e;
    int id;
    bit corr;
    pre = mdl_busy;
    if (load_valid_in && mdl_active) begin
      last_act = cyc;
      if (pre[load_id_in]) begin
        if (load_data_in !== pat(mdl_tag[load_id_in])) exp_err++;
        mdl_busy[load_id_in] = 1'b0;
        if (hold_test && load_id_in == 3'd0 && !reuse_seen) begin
          reuse_armed = 1'b1;
          reuse_cyc = cyc;
        end
      end else begin
        exp_spur++;
      end
    end
    if (hold_test && !stall_seen && pre == 8'hFF && n_st == 16 && n_ld < 16) begin
      check("full_stall_valid", 64'(valid_out), 64'd0);
      stall_seen = 1'b1;
    end
    if (valid_out && lsu_ready_in) begin
      last_act = cyc;
      if (exp_q.size() == 0) begin
        check("extra_request", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("req_op", 64'(lsu_op_out), e.is_store ? 64'(LSU_STORE) : 64'(LSU_LOAD));
        check("req_addr", 64'(addr_out), 64'(e.addr));
        if (e.is_store) begin
          check("req_data", data_out, e.data);
          n_st++;
        end else begin
          id = cur_exp_held ? held_exp_id : lowest(pre);
          check("req_id", 64'(mem_id_out), 64'(id));
          if (reuse_armed) begin
            check("reuse_id", 64'(mem_id_out), 64'd0);
            check("reuse_latency", 64'(cyc - reuse_cyc), 64'd1);
            reuse_armed = 1'b0;
            reuse_seen = 1'b1;
          end
          mdl_busy[id] = 1'b1;
          mdl_tag[id] = n_ld;
          corr = (id == corrupt_id);
          if (corr) corrupt_id = -1;
          if (!(drop_last && n_ld == 15))
            rsp_q.push_back('{id, pat(n_ld) ^ 64'(corr), cyc + 2});
          n_ld++;
        end
      end
      cur_exp_held = 1'b0;
    end else if (valid_out && lsu_op_out == LSU_LOAD && mdl_active && !cur_exp_held) begin
      cur_exp_held = 1'b1;
      held_exp_id = lowest(pre);
    end
  endtask

  task automatic drive_next();
    rsp_t r;
    load_valid_in = 1'b0;
    load_id_in    = 3'd0;
    load_data_in  = 64'd0;
    lsu_ready_in  = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
    if (hold_all && mdl_busy == 8'hFF) hold_all = 1'b0;
    if (!hold_all && rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
      r = rsp_q.pop_front();
      load_valid_in = 1'b1;
      load_id_in    = 3'(r.id);
      load_data_in  = r.data;
    end
  endtask

  task automatic tick();
    @(negedge clk_in);
    if (!cs_N_in && rst_N_in) sample_and_model();
    @(posedge clk_in);
    #1;
    cyc++;
    drive_next();
  endtask

  task automatic start_run();
    for (int i = 0; i < 16; i++) exp_q.push_back('{1'b1, 32'h1000 + 32'(i * 8), pat(i)});
    for (int i = 0; i < 16; i++) exp_q.push_back('{1'b0, 32'h1000 + 32'(i * 8), 64'd0});
    exp_err = 0; exp_spur = 0; n_st = 0; n_ld = 0;
    mdl_active = 1'b1;
    cur_exp_held = 1'b0;
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
  endtask

  task automatic finish_run(input int budget);
    for (int c = 0; c < budget && !done_out; c++) tick();
    check("run_done", 64'(done_out), 64'd1);
    check("store_count", 64'(n_st), 64'd16);
    check("load_count", 64'(n_ld), 64'd16);
    check("err_count", 64'(err_count_out), 64'(exp_err));
    check("spurious_count", 64'(spurious_count_out), 64'(exp_spur));
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_valid"}, 64'(valid_out), 64'd0);
    check({tag, "_op"}, 64'(lsu_op_out), 64'(LSU_LOAD));
    check({tag, "_id"}, 64'(mem_id_out), 64'd0);
    check({tag, "_addr"}, 64'(addr_out), 64'd0);
    check({tag, "_data"}, data_out, 64'd0);
    check({tag, "_done"}, 64'(done_out), 64'd0);
    check({tag, "_err"}, 64'(err_count_out), 64'd0);
    check({tag, "_spur"}, 64'(spurious_count_out), 64'd0);
  endtask

  initial begin
    rst_N_in = 1'b0; cs_N_in = 1'b0; start_in = 1'b0; lsu_ready_in = 1'b1;
    load_valid_in = 1'b0; load_id_in = 3'd0; load_data_in = 64'd0;
    mdl_busy = '0; cyc = 0; last_act = 0; corrupt_id = -1;
    mdl_active = 0; hold_all = 0; hold_test = 0; rand_ready = 0; drop_last = 0;
    reuse_armed = 0; reuse_seen = 0; stall_seen = 0; cur_exp_held = 0;
    repeat (3) tick();
    check_reset_values("reset");
`ifdef PROC_TRAFFIC_GEN_TIMEOUT_EN
    check("reset_timeout", 64'(timeout_out), 64'd0);
`endif
    rst_N_in = 1'b1;
    tick();

    // run 1: always ready, in-order responses two cycles after each load
    start_run();
    finish_run(500);

    // response on a free tag while DONE
    load_valid_in = 1'b1; load_id_in = 3'd5; load_data_in = pat(0);
    tick();
    check("spurious_one", 64'(spurious_count_out), 64'd1);
    check("spurious_model", 64'(spurious_count_out), 64'(exp_spur));
    check("spurious_done_kept", 64'(done_out), 64'd1);
    check("spurious_err_kept", 64'(err_count_out), 64'd0);

    // deselected: response and start are ignored
    cs_N_in = 1'b1; start_in = 1'b1;
    load_valid_in = 1'b1; load_id_in = 3'd6; load_data_in = pat(0);
    tick();
    cs_N_in = 1'b0; start_in = 1'b0;
    #1;
    check("cs_spur_hold", 64'(spurious_count_out), 64'd1);
    check("cs_done_hold", 64'(done_out), 64'd1);

    // run 2: responder holds until all tags are out; tag 3 returns corrupted data
    hold_all = 1'b1; hold_test = 1'b1; corrupt_id = 3;
    start_run();
    finish_run(500);
    check("corrupt_err_one", 64'(err_count_out), 64'd1);
    check("stall_observed", 64'(stall_seen), 64'd1);
    check("reuse_observed", 64'(reuse_seen), 64'd1);
    hold_test = 1'b0; hold_all = 1'b0; corrupt_id = -1;

`ifdef PROC_TRAFFIC_GEN_TIMEOUT_EN
    drop_last = 1'b1;
    start_run();
    finish_run(500);
    check("timeout_flag", 64'(timeout_out), 64'd1);
    check("timeout_latency", 64'(cyc - last_act - 1), 64'd20);
    drop_last = 1'b0;
    mdl_busy = '0;
    rsp_q.delete();
`endif

    // reset in the middle of the load phase
    start_run();
    for (int c = 0; c < 200 && n_ld < 5; c++) tick();
    check("five_loads_issued", 64'(n_ld), 64'd5);
    rst_N_in = 1'b0;
    tick();
    check_reset_values("midrun_reset");
    rst_N_in = 1'b1;
    mdl_busy = '0; mdl_active = 1'b0; cur_exp_held = 1'b0;
    exp_q.delete(); rsp_q.delete();
    load_valid_in = 1'b1; load_id_in = 3'd2; load_data_in = pat(2);
    tick();
    check("stale_rsp_in_idle", 64'(spurious_count_out), 64'd0);

    // run 3: restart with a randomly stalling LSU
    rand_ready = 1'b1;
    start_run();
    finish_run(800);
    rand_ready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
